multi_interval_counter: RTL

- Parametrised, multi-channel successor of the single interval counter; one instance serves every benchmark and timer channel in the test SoC.
- Each channel counts clock cycles against its own interval, pulses on expiry, and accumulates a saturating expiry count.
- Adds per-channel enable, periodic/one-shot mode, per-channel clear, an expiry pulse and sticky overflow.
- Global run control uses the existing 8-bit state bus: RESET=0, RUN=1, HALT=2.

---
 rtl/multi_interval_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/multi_interval_counter.sv
// multi_interval_counter
//   Multi-channel interval timer. Each channel counts enabled RUN cycles
//   against its own interval, pulses tick on expiry and keeps a saturating
//   expiry count with a sticky overflow flag. One-shot channels stop after
//   their first expiry until cleared.
//
// Ports
//   clk      in   1                  system clock, rising edge
//   rst      in   1                  synchronous active-high reset
//   state    in   8                  global control: 0=RESET 1=RUN 2=HALT, others=HALT
//   ch_en    in   CH_NUM             per-channel enable in RUN
//   oneshot  in   CH_NUM             per-channel mode: 0=periodic 1=one-shot
//   clr      in   CH_NUM             per-channel synchronous clear
//   inter    in   CH_NUM*CNT_WIDTH   per-channel interval, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   count    out  CH_NUM*CNT_WIDTH   per-channel saturating expiry count, same packing
//   tick     out  CH_NUM             expiry pulse
//   done     out  CH_NUM             one-shot channel expired and stopped
//   ovf      out  CH_NUM             sticky: expiry count saturated
module multi_interval_counter #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    state,
  input  logic [CH_NUM-1:0]             ch_en,
  input  logic [CH_NUM-1:0]             oneshot,
  input  logic [CH_NUM-1:0]             clr,
  input  logic [CH_NUM*CNT_WIDTH-1:0]   inter,
  output logic [CH_NUM*CNT_WIDTH-1:0]   count,
  output logic [CH_NUM-1:0]             tick,
  output logic [CH_NUM-1:0]             done,
  output logic [CH_NUM-1:0]             ovf
);

  localparam int unsigned STATE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET = 8'd0,
    ST_RUN   = 8'd1,
    ST_HALT  = 8'd2
  } run_state_e;

  // Global state decode; every code other than RESET/RUN behaves as HALT.
  logic st_reset_c;
  logic st_run_c;

  assign st_reset_c = (state == ST_RESET);
  assign st_run_c   = (state == ST_RUN);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch

    logic [CNT_WIDTH-1:0] inter_c;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 active_c;
    logic                 expire_c;

    assign inter_c = inter[g*CNT_WIDTH +: CNT_WIDTH];

    // Channel advances only when running, enabled and not a finished one-shot.
    assign active_c = st_run_c && ch_en[g] && !done_q;

    // >= so that shrinking the interval below the current phase expires at once.
    assign expire_c = (cyc_q >= inter_c);

    // Next-state: state RESET > clr > RUN update > hold (tick always drops on hold).
    always_comb begin
      cyc_d  = cyc_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      done_d = done_q;
      ovf_d  = ovf_q;
      if (st_reset_c || clr[g]) begin
        cyc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        ovf_d  = 1'b0;
      end else if (active_c) begin
        if (expire_c) begin
          cyc_d  = '0;
          tick_d = 1'b1;
          // Saturate instead of wrapping; saturation attempt raises sticky ovf.
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (oneshot[g]) begin
            done_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CNT_WIDTH'(1);
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        cyc_q  <= '0;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        cyc_q  <= cyc_d;
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        done_q <= done_d;
        ovf_q  <= ovf_d;
      end
    end

    assign count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    assign tick[g]                         = tick_q;
    assign done[g]                         = done_q;
    assign ovf[g]                          = ovf_q;

  end : g_ch

endmodule : multi_interval_counter
